// File: rtl/cpu_fetch_pkg.sv
// Shared CPU defines: instruction opcodes, tag width, fetch/decode hand-off
// records and the opcode-to-format classification used by fetch.
package cpu_fetch_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 8;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_AMO      = 7'b0101111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_FMADD    = 7'b1000011;
  localparam logic [6:0] OPC_FMSUB    = 7'b1000111;
  localparam logic [6:0] OPC_FNMSUB   = 7'b1001011;
  localparam logic [6:0] OPC_FNMADD   = 7'b1001111;
  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_R4,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } inst_format_t;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [31:0]      instruction;
    logic [4:0]       inst_rs1;
    logic [4:0]       inst_rs2;
    logic [4:0]       inst_rs3;
    logic [4:0]       inst_rd;
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
  } fetch_data_t;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  rs1_value;
    logic [XLEN-1:0]  rs2_value;
    logic [XLEN-1:0]  rs3_value;
    logic [XLEN-1:0]  imm;
    logic [4:0]       inst_rd;
    logic [TAG_W-1:0] tag;
  } decode_data_t;

  // Anything not listed is treated as I-format.
  function automatic inst_format_t opcode_format(input logic [6:0] opcode);
    case (opcode)
      OPC_OP, OPC_OP_FP, OPC_AMO:                     return FMT_R;
      OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD:   return FMT_R4;
      OPC_STORE, OPC_STORE_FP:                        return FMT_S;
      OPC_BRANCH:                                     return FMT_B;
      OPC_LUI, OPC_AUIPC:                             return FMT_U;
      OPC_JAL:                                        return FMT_J;
      default:                                        return FMT_I;
    endcase
  endfunction

  // Control transfers whose target is resolved downstream.
  function automatic logic is_jump_opcode(input logic [6:0] opcode);
    return (opcode == OPC_JAL) || (opcode == OPC_JALR) || (opcode == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/cpu_fetch_immediate.sv
// Combinational register-field and immediate extraction for one RV32 word.
// Ports:
//   instruction : 32-bit instruction word
//   rs1/rs2/rs3 : source register indices (0 when the format has none)
//   rd          : destination register index (0 for S/B formats)
//   imm         : immediate, extended per format
module cpu_fetch_immediate
  import cpu_fetch_pkg::*;
(
  input  logic [31:0] instruction,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rs3,
  output logic [4:0]  rd,
  output logic [31:0] imm
);

  logic [6:0]   opcode;
  inst_format_t fmt;

  assign opcode = instruction[6:0];
  assign fmt    = opcode_format(opcode);

  always_comb begin
    rs1 = '0;
    rs2 = '0;
    rs3 = '0;
    rd  = '0;
    imm = '0;

    if (!(fmt inside {FMT_S, FMT_B}))
      rd = instruction[11:7];
    if (!(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL}))
      rs1 = instruction[19:15];
    if (fmt inside {FMT_R, FMT_R4, FMT_S, FMT_B})
      rs2 = instruction[24:20];
    if (fmt == FMT_R4)
      rs3 = instruction[31:27];

    case (fmt)
      FMT_I: begin
        if (opcode == OPC_SYSTEM)
          imm = {20'b0, instruction[31:20]};
        else if ((opcode == OPC_OP_IMM) && (instruction[13:12] == 2'b01))
          imm = {26'b0, instruction[25:20]};   // shift amount plus funct7 low bit
        else
          imm = {{20{instruction[31]}}, instruction[31:20]};
      end
      FMT_S:
        imm = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      FMT_B:
        imm = {{19{instruction[31]}}, instruction[31], instruction[7],
               instruction[30:25], instruction[11:8], 1'b0};
      FMT_U:
        imm = {instruction[31:12], 12'b0};
      FMT_J:
        imm = {{11{instruction[31]}}, instruction[31], instruction[19:12],
               instruction[20], instruction[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch stage: requests words at pc, hands them to decode one at a
// time, buffers a word while decode stalls, and waits for the resolved target
// after any jump or branch.
// Ports:
//   i_clock, i_reset          : clock, synchronous active-high reset
//   o_fault                   : sticky fetch fault
//   o_bus_request             : read request, held until i_bus_ready
//   o_bus_address             : request address (= pc)
//   i_bus_ready, i_bus_rdata  : request accepted / instruction word
//   i_stall                   : decode cannot accept a new instruction
//   i_jump_valid, i_jump_pc   : resolved next pc strobe
//   o_data                    : issued instruction; tag increments per issue
// Build option: CPU_FETCH_ALIGN_CHECK_EN -- a misaligned resolved pc raises
// o_fault and parks the stage until reset; otherwise low pc bits are dropped.
module cpu_fetch
  import cpu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic        o_fault,
  output logic        o_bus_request,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_stall,
  input  logic        i_jump_valid,
  input  logic [31:0] i_jump_pc,
  output fetch_data_t o_data
);

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    WAIT_JUMP,
    FAULT
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] held_word;
  fetch_data_t data;

  logic [31:0] issue_word;
  logic        issue_jump;
  fetch_data_t issued;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rs3;
  logic [4:0]  dec_rd;
  logic [31:0] dec_imm;

  // In HOLD the buffered word is the one being issued; the bus is ignored.
  assign issue_word = (state == HOLD) ? held_word : i_bus_rdata;
  assign issue_jump = is_jump_opcode(issue_word[6:0]);

  cpu_fetch_immediate u_immediate (
    .instruction (issue_word),
    .rs1         (dec_rs1),
    .rs2         (dec_rs2),
    .rs3         (dec_rs3),
    .rd          (dec_rd),
    .imm         (dec_imm)
  );

  always_comb begin
    issued             = '0;
    issued.pc          = pc;
    issued.instruction = issue_word;
    issued.inst_rs1    = dec_rs1;
    issued.inst_rs2    = dec_rs2;
    issued.inst_rs3    = dec_rs3;
    issued.inst_rd     = dec_rd;
    issued.imm         = dec_imm;
    issued.tag         = data.tag + 8'd1;
  end

`ifdef CPU_FETCH_ALIGN_CHECK_EN
  logic fault;
`else
  logic unused_jump_lsbs;
  assign unused_jump_lsbs = ^i_jump_pc[1:0];
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state     <= FETCH;
      pc        <= RESET_VECTOR;
      held_word <= '0;
      data      <= '0;
`ifdef CPU_FETCH_ALIGN_CHECK_EN
      fault     <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH: begin
          if (i_bus_ready) begin
            if (i_stall) begin
              held_word <= i_bus_rdata;
              state     <= HOLD;
            end else begin
              data <= issued;
              if (issue_jump) begin
                state <= WAIT_JUMP;
              end else begin
                pc    <= pc + 32'd4;
                state <= FETCH;
              end
            end
          end
        end
        HOLD: begin
          if (!i_stall) begin
            data <= issued;
            if (issue_jump) begin
              state <= WAIT_JUMP;
            end else begin
              pc    <= pc + 32'd4;
              state <= FETCH;
            end
          end
        end
        WAIT_JUMP: begin
          if (i_jump_valid) begin
`ifdef CPU_FETCH_ALIGN_CHECK_EN
            if (i_jump_pc[1:0] != 2'b00) begin
              fault <= 1'b1;
              state <= FAULT;
            end else begin
              pc    <= i_jump_pc;
              state <= FETCH;
            end
`else
            pc    <= {i_jump_pc[31:2], 2'b00};
            state <= FETCH;
`endif
          end
        end
        FAULT: begin
          state <= FAULT;
        end
      endcase
    end
  end

  // Request is gated by reset so that no read is presented while reset is held.
  assign o_bus_request = (state == FETCH) && !i_reset;
  assign o_bus_address = pc;
  assign o_data        = data;
`ifdef CPU_FETCH_ALIGN_CHECK_EN
  assign o_fault       = fault;
`else
  assign o_fault       = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_fetch.sv
module tb_cpu_fetch;
  import cpu_fetch_pkg::*;

  localparam logic [31:0] RV      = 32'h0000_0100;
  localparam logic [31:0] W_ADDI5 = 32'h0050_0093;
  localparam logic [31:0] W_BEQ   = 32'hFE00_0EE3;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        o_fault;
  logic        o_bus_request;
  logic        i_bus_ready;
  logic [31:0] o_bus_address;
  logic [31:0] i_bus_rdata;
  logic        i_stall;
  logic        i_jump_valid;
  logic [31:0] i_jump_pc;
  fetch_data_t o_data;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [7:0]  exp_tag;
  logic [31:0] exp_pc;

  typedef struct {
    logic [31:0] word;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rs3;
    logic [31:0] imm;
    bit          jump;
  } vec_t;

  vec_t vecs[13];

  cpu_fetch #(.RESET_VECTOR(RV)) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .o_fault       (o_fault),
    .o_bus_request (o_bus_request),
    .i_bus_ready   (i_bus_ready),
    .o_bus_address (o_bus_address),
    .i_bus_rdata   (i_bus_rdata),
    .i_stall       (i_stall),
    .i_jump_valid  (i_jump_valid),
    .i_jump_pc     (i_jump_pc),
    .o_data        (o_data)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{32'h002081B3, 5'd3, 5'd1, 5'd2, 5'd0, 32'h0000_0000, 1'b0}; // add
    vecs[1]  = '{32'h00512423, 5'd0, 5'd2, 5'd5, 5'd0, 32'h0000_0008, 1'b0}; // sw
    vecs[2]  = '{32'h123453B7, 5'd7, 5'd0, 5'd0, 5'd0, 32'h1234_5000, 1'b0}; // lui
    vecs[3]  = '{32'h4030D213, 5'd4, 5'd1, 5'd0, 5'd0, 32'h0000_0003, 1'b0}; // srai
    vecs[4]  = '{32'hFFF090F3, 5'd1, 5'd1, 5'd0, 5'd0, 32'h0000_0FFF, 1'b0}; // csrrw
    vecs[5]  = '{32'hFFF00093, 5'd1, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0}; // addi -1
    vecs[6]  = '{32'h203100C3, 5'd1, 5'd2, 5'd3, 5'd4, 32'h0000_0000, 1'b0}; // fmadd
    vecs[7]  = '{32'hFFFFF297, 5'd5, 5'd0, 5'd0, 5'd0, 32'hFFFF_F000, 1'b0}; // auipc
    vecs[8]  = '{32'h010000EF, 5'd1, 5'd0, 5'd0, 5'd0, 32'h0000_0010, 1'b1}; // jal
    vecs[9]  = '{32'h00408067, 5'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0004, 1'b1}; // jalr
    vecs[10] = '{32'hFFC12303, 5'd6, 5'd2, 5'd0, 5'd0, 32'hFFFF_FFFC, 1'b0}; // lw
    vecs[11] = '{32'h00209463, 5'd0, 5'd1, 5'd2, 5'd0, 32'h0000_0008, 1'b1}; // bne
    vecs[12] = '{32'hFE102FA3, 5'd0, 5'd0, 5'd1, 5'd0, 32'hFFFF_FFFF, 1'b0}; // sw -1

    i_reset = 1'b1; i_bus_ready = 1'b0; i_stall = 1'b0;
    i_jump_valid = 1'b0; i_jump_pc = '0; i_bus_rdata = '0;
    step(); step();
    check("reset_req", o_bus_request, 32'd0);
    check("reset_tag", o_data.tag, 32'd0);
    check("reset_pc_field", o_data.pc, 32'd0);
    check("reset_fault", o_fault, 32'd0);

    // First fetch after reset
    i_reset = 1'b0;
    #1;
    check("first_req", o_bus_request, 32'd1);
    check("first_addr", o_bus_address, RV);
    i_bus_ready = 1'b1; i_bus_rdata = W_ADDI5;
    step();
    i_bus_ready = 1'b0;
    check("addi_tag", o_data.tag, 32'd1);
    check("addi_pc", o_data.pc, 32'h100);
    check("addi_rd", o_data.inst_rd, 32'd1);
    check("addi_rs1", o_data.inst_rs1, 32'd0);
    check("addi_imm", o_data.imm, 32'd5);
    check("addi_instr", o_data.instruction, W_ADDI5);
    #1;
    check("addi_next_req", o_bus_request, 32'd1);
    check("addi_next_addr", o_bus_address, 32'h104);

    // Stall while word at 0x104 is accepted: three stalled edges
    i_bus_ready = 1'b1; i_bus_rdata = 32'h00A00113; i_stall = 1'b1;
    step();
    i_bus_rdata = 32'hDEADBEEF;
    #1;
    check("hold_req0", o_bus_request, 32'd0);
    check("hold_tag0", o_data.tag, 32'd1);
    step();
    check("hold_req1", o_bus_request, 32'd0);
    check("hold_tag1", o_data.tag, 32'd1);
    step();
    check("hold_tag2", o_data.tag, 32'd1);
    i_stall = 1'b0; i_bus_ready = 1'b0;
    step();
    check("unstall_tag", o_data.tag, 32'd2);
    check("unstall_pc", o_data.pc, 32'h104);
    check("unstall_rd", o_data.inst_rd, 32'd2);
    check("unstall_imm", o_data.imm, 32'd10);
    check("unstall_instr", o_data.instruction, 32'h00A00113);
    check("unstall_req", o_bus_request, 32'd1);
    check("unstall_addr", o_bus_address, 32'h108);
    step();
    check("no_dup_tag", o_data.tag, 32'd2);

    // Branch then resolved target three cycles later
    i_bus_ready = 1'b1; i_bus_rdata = W_BEQ;
    step();
    check("beq_tag", o_data.tag, 32'd3);
    check("beq_pc", o_data.pc, 32'h108);
    check("beq_imm", o_data.imm, 32'hFFFF_FFFC);
    check("beq_rd", o_data.inst_rd, 32'd0);
    check("beq_req", o_bus_request, 32'd0);
    check("beq_addr_hold", o_bus_address, 32'h108);
    step(); step();
    check("wait_req", o_bus_request, 32'd0);
    check("wait_tag", o_data.tag, 32'd3);
    i_jump_valid = 1'b1; i_jump_pc = 32'h200;
    step();
    i_jump_valid = 1'b0; i_bus_ready = 1'b0;
    #1;
    check("jump_req", o_bus_request, 32'd1);
    check("jump_addr", o_bus_address, 32'h200);
    check("jump_tag", o_data.tag, 32'd3);
    // Jump strobe outside WAIT_JUMP is ignored
    i_jump_valid = 1'b1; i_jump_pc = 32'h300;
    step();
    i_jump_valid = 1'b0;
    #1;
    check("stray_jump_addr", o_bus_address, 32'h200);
    check("stray_jump_req", o_bus_request, 32'd1);

    // Decode table
    exp_pc = 32'h200; exp_tag = 8'd3;
    foreach (vecs[k]) begin
      i_bus_rdata = vecs[k].word; i_bus_ready = 1'b1;
      step();
      i_bus_ready = 1'b0;
      exp_tag = exp_tag + 8'd1;
      check($sformatf("v%0d_pc", k), o_data.pc, exp_pc);
      check($sformatf("v%0d_tag", k), o_data.tag, exp_tag);
      check($sformatf("v%0d_instr", k), o_data.instruction, vecs[k].word);
      check($sformatf("v%0d_rd", k), o_data.inst_rd, vecs[k].rd);
      check($sformatf("v%0d_rs1", k), o_data.inst_rs1, vecs[k].rs1);
      check($sformatf("v%0d_rs2", k), o_data.inst_rs2, vecs[k].rs2);
      check($sformatf("v%0d_rs3", k), o_data.inst_rs3, vecs[k].rs3);
      check($sformatf("v%0d_imm", k), o_data.imm, vecs[k].imm);
      if (vecs[k].jump) begin
        #1;
        check($sformatf("v%0d_jreq", k), o_bus_request, 32'd0);
        exp_pc = 32'h400 + 32'(k) * 32'd32;
        i_jump_valid = 1'b1; i_jump_pc = exp_pc;
        step();
        i_jump_valid = 1'b0;
      end else begin
        exp_pc = exp_pc + 32'd4;
      end
      #1;
      check($sformatf("v%0d_addr", k), o_bus_address, exp_pc);
      check($sformatf("v%0d_req", k), o_bus_request, 32'd1);
    end

    // Tag wrap across 255 -> 0 with back-to-back issue
    i_bus_ready = 1'b1; i_bus_rdata = W_ADDI5;
    for (int n = 0; n < 260; n++) begin
      step();
      exp_tag = exp_tag + 8'd1;
      check($sformatf("wrap%0d_tag", n), o_data.tag, exp_tag);
      check($sformatf("wrap%0d_pc", n), o_data.pc, exp_pc);
      exp_pc = exp_pc + 32'd4;
    end
    i_bus_ready = 1'b0;
    #1;
    check("wrap_addr", o_bus_address, exp_pc);

    // Misaligned resolved pc
    i_bus_ready = 1'b1; i_bus_rdata = W_BEQ;
    step();
    i_bus_ready = 1'b0;
    exp_tag = exp_tag + 8'd1;
    check("mis_beq_tag", o_data.tag, exp_tag);
    i_jump_valid = 1'b1; i_jump_pc = 32'h202;
    step();
    i_jump_valid = 1'b0;
    #1;
`ifdef CPU_FETCH_ALIGN_CHECK_EN
    check("mis_fault", o_fault, 32'd1);
    check("mis_req", o_bus_request, 32'd0);
    i_bus_ready = 1'b1; i_bus_rdata = W_ADDI5;
    step(); step();
    i_bus_ready = 1'b0;
    check("mis_req_later", o_bus_request, 32'd0);
    check("mis_tag_later", o_data.tag, exp_tag);
    check("mis_fault_later", o_fault, 32'd1);
`else
    check("mis_fault", o_fault, 32'd0);
    check("mis_req", o_bus_request, 32'd1);
    check("mis_addr", o_bus_address, 32'h200);
`endif

    // Reset while a word is buffered in HOLD
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    #1;
    check("rst2_req", o_bus_request, 32'd1);
    check("rst2_addr", o_bus_address, RV);
    check("rst2_tag", o_data.tag, 32'd0);
    check("rst2_fault", o_fault, 32'd0);
    i_bus_ready = 1'b1; i_stall = 1'b1; i_bus_rdata = 32'h00700393;
    step();
    i_bus_ready = 1'b0;
    #1;
    check("rst_hold_req", o_bus_request, 32'd0);
    i_reset = 1'b1; i_stall = 1'b0;
    #1;
    check("rst_in_reset_req", o_bus_request, 32'd0);
    step();
    check("rst_hold_tag", o_data.tag, 32'd0);
    i_reset = 1'b0;
    #1;
    check("rst_hold_first_req", o_bus_request, 32'd1);
    check("rst_hold_first_addr", o_bus_address, RV);
    step(); step();
    check("rst_hold_no_issue", o_data.tag, 32'd0);
    i_bus_ready = 1'b1; i_bus_rdata = W_ADDI5;
    step();
    i_bus_ready = 1'b0;
    check("rst_after_tag", o_data.tag, 32'd1);
    check("rst_after_pc", o_data.pc, RV);
    check("rst_after_instr", o_data.instruction, W_ADDI5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_fetch.md
CPU_FETCH -- requirements
Module: cpu_fetch

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, first instruction address after reset.
REQ-002 SHALL have i_clock  input  1  rising-edge clock.
REQ-003 SHALL have i_reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have o_fault  output  1  sticky fetch fault.
REQ-005 SHALL have o_bus_request  output  1  instruction read request, held until accepted.
REQ-006 SHALL have i_bus_ready  input  1  request accepted; i_bus_rdata valid this cycle.
REQ-007 SHALL have o_bus_address  output  32  word address of request (= pc).
REQ-008 SHALL have i_bus_rdata  input  32  instruction word.
REQ-009 SHALL have i_stall  input  1  decode cannot accept a new instruction.
REQ-010 SHALL have i_jump_valid  input  1  one-cycle strobe, resolved next pc available.
REQ-011 SHALL have i_jump_pc  input  32  resolved next pc.
REQ-012 SHALL have o_data  output  fetch_data_t  pc, instruction, inst_rs1/rs2/rs3, inst_rd, imm, tag (8 bit).

Function
REQ-013 SHALL implement FSM states FETCH, HOLD, WAIT_JUMP, FAULT.
REQ-014 FETCH: o_bus_request=1, o_bus_address=pc; on i_bus_ready with i_stall=0 SHALL issue the word on that edge; with i_stall=1 SHALL buffer it and go to HOLD.
REQ-015 HOLD: o_bus_request=0; SHALL issue buffered word on first edge with i_stall=0.
REQ-016 Issue SHALL update all o_data fields in one edge and increment tag by 1, wrapping 255->0; o_data SHALL otherwise hold its value (tag change is the only new-instruction indication).
REQ-017 After issuing non-jump: pc<=pc+4 (mod 2^32), state FETCH; next request asserted in the following cycle.
REQ-018 After issuing opcode 1101111 (JAL), 1100111 (JALR) or 1100011 (BRANCH): state WAIT_JUMP, o_bus_request=0, pc unchanged.
REQ-019 WAIT_JUMP: on i_jump_valid SHALL load pc<=i_jump_pc and go to FETCH; i_jump_valid in any other state SHALL be ignored.
REQ-020 inst_rd=[11:7] except 0 for S/B formats; inst_rs1=[19:15] except 0 for LUI, AUIPC, JAL; inst_rs2=[24:20] only for R, S, B formats (incl. R4), else 0; inst_rs3=[31:27] only for opcodes 1000011/1000111/1001011/1001111, else 0.
REQ-021 imm SHALL be sign-extended per format: I, S, B, U, J standard RV32I; shifts (opcode 0010011, funct3 x01) zero-extended [25:20]; SYSTEM (1110011) zero-extended [31:20]; R format 0.
REQ-022 i_stall SHALL never cause loss or duplication of a fetched word; i_bus_ready outside FETCH SHALL be ignored.
REQ-023 Issue latency: word accepted at edge N with i_stall=0 appears on o_data after edge N.

Reset
REQ-024 On i_reset: pc<=RESET_VECTOR, state FETCH, o_data<=0 (tag 0), o_fault<=0; o_bus_request SHALL be 0 during reset cycles.
REQ-025 Reset mid-operation (any state, incl. HOLD/WAIT_JUMP) SHALL discard buffered word and pending jump; first request in cycle after i_reset deasserts.

Configuration
REQ-026 Macro CPU_FETCH_ALIGN_CHECK_EN defined: i_jump_pc[1:0]!=0 in WAIT_JUMP SHALL set o_fault=1 and enter FAULT (no requests, no issue) until reset.
REQ-027 Macro undefined: pc<={i_jump_pc[31:2],2'b00}, FAULT unreachable, o_fault constant 0.

Structure
REQ-028 fetch_data_t, opcode constants and tag width SHALL live in the shared CPU defines package alongside decode_data_t.
REQ-029 Immediate/register-field extraction SHALL be a combinational sub-module cpu_fetch_immediate; FSM, pc, buffer remain in cpu_fetch.

Verification
REQ-030 Reset RESET_VECTOR=32'h100, ready every cycle, word 32'h00500093 (addi x1,x0,5): o_data.pc=0x100, rd=1, rs1=0, imm=5, tag=1; next request address 0x104.
REQ-031 i_stall=1 for 3 cycles when word at 0x104 accepted: o_bus_request=0 in HOLD, tag unchanged; tag=2 on first edge after i_stall=0, no duplicate issue.
REQ-032 Word 32'hFE000EE3 (beq x0,x0,-4) issued: request drops, WAIT_JUMP; i_jump_valid with i_jump_pc=0x200 3 cycles later -> next request address 0x200.
REQ-033 Tag wrap: issue 256 instructions -> tag sequence ... 254, 255, 0, 1.
REQ-034 i_jump_pc=0x202 with CPU_FETCH_ALIGN_CHECK_EN: o_fault=1, no further requests until reset; without macro: request address 0x200, o_fault=0.
REQ-035 i_reset asserted in HOLD: buffered word never issued, o_data.tag=0, first request at RESET_VECTOR.
